// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad number-entry block.
//   - 4-bit key codes produced by the coordinate decoder
//   - Encoding of the ENTRY / CONVERT / HOLD states
//   - Helper functions that map a row or column nibble to a key
package keypad_pkg;

    // Key codes. Digits keep their numeric value so they can go straight into the BCD buffer.
    localparam logic [3:0] KEY_0     = 4'd0;
    localparam logic [3:0] KEY_1     = 4'd1;
    localparam logic [3:0] KEY_2     = 4'd2;
    localparam logic [3:0] KEY_3     = 4'd3;
    localparam logic [3:0] KEY_4     = 4'd4;
    localparam logic [3:0] KEY_5     = 4'd5;
    localparam logic [3:0] KEY_6     = 4'd6;
    localparam logic [3:0] KEY_7     = 4'd7;
    localparam logic [3:0] KEY_8     = 4'd8;
    localparam logic [3:0] KEY_9     = 4'd9;
    localparam logic [3:0] KEY_CLR   = 4'hA;
    localparam logic [3:0] KEY_NEG   = 4'hB;
    localparam logic [3:0] KEY_BKSP  = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hD;
    localparam logic [3:0] KEY_C     = 4'hE;
    localparam logic [3:0] KEY_D     = 4'hF;
    // All 16 code points are already used by real keys. KEY_NONE is only
    // meaningful while the decoder's valid flag is low.
    localparam logic [3:0] KEY_NONE  = 4'h0;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_CONVERT = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    // True when the active-low nibble has exactly one zero bit.
    function automatic logic one_zero(input logic [3:0] n);
        return (n == 4'b0111) || (n == 4'b1011) || (n == 4'b1101) || (n == 4'b1110);
    endfunction

    // Position of the zero bit: 0111 -> 0 (top row / left column).
    function automatic logic [1:0] zero_pos(input logic [3:0] n);
        case (n)
            4'b0111: return 2'd0;
            4'b1011: return 2'd1;
            4'b1101: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Keypad layout, indexed by {row, col}.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'd0:    return KEY_1;
            4'd1:    return KEY_2;
            4'd2:    return KEY_3;
            4'd3:    return KEY_CLR;
            4'd4:    return KEY_4;
            4'd5:    return KEY_5;
            4'd6:    return KEY_6;
            4'd7:    return KEY_NEG;
            4'd8:    return KEY_7;
            4'd9:    return KEY_8;
            4'd10:   return KEY_9;
            4'd11:   return KEY_C;
            4'd12:   return KEY_BKSP;
            4'd13:   return KEY_0;
            4'd14:   return KEY_ENTER;
            default: return KEY_D;
        endcase
    endfunction

endpackage

// File: rtl/keypad_coord_decoder.sv
// Combinational decoder that turns a keypad coordinate into a key code.
// Ports:
//   coord_i [7:0]  {row[3:0], col[3:0]}; both nibbles active-low one-hot; 8'h00 = idle
//   code_o  [3:0]  decoded key code (KEY_NONE when valid_o = 0)
//   valid_o        well-formed, non-idle coordinate
//   err_o          non-idle coordinate where a nibble does not have exactly one zero
module keypad_coord_decoder
    import keypad_pkg::*;
(
    input  logic [7:0] coord_i,
    output logic [3:0] code_o,
    output logic       valid_o,
    output logic       err_o
);

    logic [3:0] row;
    logic [3:0] col;

    assign row = coord_i[7:4];
    assign col = coord_i[3:0];

    always_comb begin
        code_o  = KEY_NONE;
        valid_o = 1'b0;
        err_o   = 1'b0;
        if (coord_i != 8'h00) begin
            if (one_zero(row) && one_zero(col)) begin
                valid_o = 1'b1;
                code_o  = key_map(zero_pos(row), zero_pos(col));
            end else begin
                err_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_number_entry.sv
// Keypad number entry: builds a signed decimal number from key events,
// converts the BCD buffer to binary, and offers the result on a valid/ready port.
// All state changes on the falling clock edge, the same edge the scanner uses.
// Ports:
//   clk, rst_n              clock (negedge active), asynchronous active-low reset
//   key_coord [7:0]         one-cycle key coordinate pulse from the scanner
//   out_data  [DATA_W-1:0]  converted two's-complement value
//   out_valid / out_ready   result handshake
//   disp_bcd / disp_len / disp_neg   live entry buffer for the display
//   busy                    high in CONVERT and HOLD; key events are dropped then
//   key_err                 one-cycle pulse for a malformed coordinate
//   dbg_state [1:0]         current FSM state (keypad_pkg::state_e encoding)
// Handshake: out_data is stable while out_valid is high. The value transfers at
// the first active edge where out_valid and out_ready are both high. out_ready
// has no effect at any other time.
// Optional feature: define KEYPAD_AUTO_SUBMIT_EN to start the conversion as soon
// as the buffer fills.
module keypad_number_entry
    import keypad_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MAX_DIGITS = 8,
    parameter int LEN_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              key_coord,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*MAX_DIGITS-1:0] disp_bcd,
    output logic [LEN_W-1:0]        disp_len,
    output logic                    disp_neg,
    output logic                    busy,
    output logic                    key_err,
    output logic [1:0]              dbg_state
);

    localparam int               BCD_W   = 4 * MAX_DIGITS;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_DIGITS);

    logic [3:0] key_code;
    logic       key_valid;
    logic       key_err_c;

    keypad_coord_decoder u_decoder (
        .coord_i (key_coord),
        .code_o  (key_code),
        .valid_o (key_valid),
        .err_o   (key_err_c)
    );

    state_e             state_q,     state_d;
    logic [BCD_W-1:0]   bcd_q,       bcd_d;
    logic [LEN_W-1:0]   len_q,       len_d;
    logic               neg_q,       neg_d;
    logic [DATA_W-1:0]  acc_q,       acc_d;
    logic [LEN_W-1:0]   idx_q,       idx_d;
    logic [DATA_W-1:0]  out_data_q,  out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               key_err_q;

    // Digit currently being folded into the accumulator, oldest digit first.
    logic [3:0]        cur_digit;
    logic [DATA_W-1:0] acc_mul;

    assign cur_digit = 4'(bcd_q >> {idx_q, 2'b00});
    // acc * 10 + digit, built from shifts so no multiplier is inferred.
    assign acc_mul   = (acc_q << 3) + (acc_q << 1) + DATA_W'(cur_digit);

    always_comb begin
        state_d     = state_q;
        bcd_d       = bcd_q;
        len_d       = len_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_ENTRY: begin
                if (key_valid) begin
                    case (key_code)
                        KEY_CLR: begin
                            bcd_d = '0;
                            len_d = '0;
                            neg_d = 1'b0;
                        end
                        KEY_NEG: neg_d = ~neg_q;
                        KEY_BKSP: begin
                            if (len_q != '0) begin
                                bcd_d = bcd_q >> 4;
                                len_d = len_q - LEN_ONE;
                            end
                        end
                        KEY_ENTER: begin
                            if (len_q != '0) begin
                                acc_d   = '0;
                                idx_d   = len_q - LEN_ONE;
                                state_d = ST_CONVERT;
                            end
                        end
                        KEY_C, KEY_D: ;
                        default: begin
                            // Remaining codes are the digits 0-9.
                            if (len_q < LEN_MAX) begin
                                bcd_d = (bcd_q << 4) | BCD_W'(key_code);
                                len_d = len_q + LEN_ONE;
`ifdef KEYPAD_AUTO_SUBMIT_EN
                                if (len_q == LEN_MAX - LEN_ONE) begin
                                    acc_d   = '0;
                                    idx_d   = LEN_MAX - LEN_ONE;
                                    state_d = ST_CONVERT;
                                end
`endif
                            end
                        end
                    endcase
                end
            end

            ST_CONVERT: begin
                acc_d = acc_mul;
                if (idx_q == '0) begin
                    // Negating zero gives zero, so a "-0" entry needs no special case.
                    out_data_d  = neg_q ? -acc_mul : acc_mul;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    idx_d = idx_q - LEN_ONE;
                end
            end

            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    bcd_d       = '0;
                    len_d       = '0;
                    neg_d       = 1'b0;
                    state_d     = ST_ENTRY;
                end
            end

            default: state_d = ST_ENTRY;
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ENTRY;
            bcd_q       <= '0;
            len_q       <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcd_q       <= bcd_d;
            len_q       <= len_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            // A malformed coordinate is flagged in every state.
            key_err_q   <= key_err_c;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign disp_bcd  = bcd_q;
    assign disp_len  = len_q;
    assign disp_neg  = neg_q;
    assign busy      = (state_q != ST_ENTRY);
    assign key_err   = key_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_number_entry.sv
module tb_keypad_number_entry;

    localparam int DATA_W     = 32;
    localparam int MAX_DIGITS = 8;
    localparam int LEN_W      = 4;

    logic                    clk;
    logic                    rst_n;
    logic [7:0]              key_coord;
    logic [DATA_W-1:0]       out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [4*MAX_DIGITS-1:0] disp_bcd;
    logic [LEN_W-1:0]        disp_len;
    logic                    disp_neg;
    logic                    busy;
    logic                    key_err;
    logic [1:0]              dbg_state;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: digits as integers, oldest first, plus the sign flag.
    int mdig[$];
    bit mneg;

    string key_layout = "123A456B789C*0#D";

    keypad_number_entry #(
        .DATA_W     (DATA_W),
        .MAX_DIGITS (MAX_DIGITS),
        .LEN_W      (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_coord (key_coord),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .disp_bcd  (disp_bcd),
        .disp_len  (disp_len),
        .disp_neg  (disp_neg),
        .busy      (busy),
        .key_err   (key_err),
        .dbg_state (dbg_state)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Helpers
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] coord_of(input byte k);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 16; i++)
            if (key_layout[i] == k)
                c = {~(4'b1000 >> (i / 4)), ~(4'b1000 >> (i % 4))};
        return c;
    endfunction

    function automatic logic [31:0] model_bcd();
        logic [31:0] r;
        int n;
        r = '0;
        n = mdig.size();
        for (int i = 0; i < n; i++)
            r[4*i +: 4] = 4'(mdig[n-1-i]);
        return r;
    endfunction

    function automatic logic [31:0] model_value();
        longint v;
        v = 0;
        foreach (mdig[i]) v = v * 10 + mdig[i];
        if (mneg) v = -v;
        return v[31:0];
    endfunction

    task automatic model_key(input byte k);
        if (k >= "0" && k <= "9") begin
            if (mdig.size() < MAX_DIGITS) mdig.push_back(int'(k - "0"));
        end else if (k == "*") begin
            if (mdig.size() > 0) void'(mdig.pop_back());
        end else if (k == "A") begin
            mdig.delete();
            mneg = 1'b0;
        end else if (k == "B") begin
            mneg = ~mneg;
        end
    endtask

    // Drive a one-cycle coordinate pulse; returns at the rising edge after the sampling edge.
    task automatic press_coord(input logic [7:0] c);
        @(posedge clk);
        key_coord = c;
        @(posedge clk);
        key_coord = 8'h00;
    endtask

    task automatic press_key(input byte k, input bit update_model);
        press_coord(coord_of(k));
        if (update_model) model_key(k);
    endtask

    task automatic check_disp(input string tag);
        chk({tag, "_len"}, disp_len, mdig.size());
        chk({tag, "_bcd"}, disp_bcd, model_bcd());
        chk({tag, "_neg"}, disp_neg, mneg);
    endtask

    // Wait for out_valid with a cycle budget; n = rising edges waited.
    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            n++;
        end
    endtask

    // Submit with '#' (or the submit has already happened when skip_enter),
    // check latency and value, then complete the handshake.
    task automatic run_enter(input string tag, input bit ready_now, input int hold_cycles,
                             input bit skip_enter);
        int n;
        int exp_len;
        logic [31:0] exp_v;
        exp_len = mdig.size();
        exp_v   = model_value();
        out_ready = ready_now;
        if (!skip_enter) press_key("#", 1'b0);
        chk({tag, "_busy"}, busy, 1'b1);
        wait_valid(n);
        chk({tag, "_latency"}, n, exp_len);
        chk({tag, "_data"}, out_data, exp_v);
        if (!ready_now) begin
            for (int i = 0; i < hold_cycles; i++) begin
                @(posedge clk);
                chk({tag, "_hold_valid"}, out_valid, 1'b1);
                chk({tag, "_hold_data"}, out_data, exp_v);
            end
            press_key("7", 1'b0);
            chk({tag, "_hold_drop"}, disp_len, exp_len);
            chk({tag, "_hold_valid2"}, out_valid, 1'b1);
            out_ready = 1'b1;
        end
        @(posedge clk);
        out_ready = 1'b0;
        mdig.delete();
        mneg = 1'b0;
        chk({tag, "_done_valid"}, out_valid, 1'b0);
        chk({tag, "_done_len"}, disp_len, 0);
        chk({tag, "_done_busy"}, busy, 1'b0);
        chk({tag, "_done_neg"}, disp_neg, 1'b0);
    endtask

    // Directed and random stimulus
    initial begin
        rst_n     = 1'b0;
        key_coord = 8'h00;
        out_ready = 1'b0;
        mneg      = 1'b0;
        repeat (3) @(posedge clk);

        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_disp_bcd", disp_bcd, 0);
        chk("rst_disp_len", disp_len, 0);
        chk("rst_disp_neg", disp_neg, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_key_err", key_err, 1'b0);
        chk("rst_state", dbg_state, keypad_pkg::ST_ENTRY);
        rst_n = 1'b1;
        @(posedge clk);

        // 1: 123 with out_ready already high
        press_key("1", 1'b1);
        press_key("2", 1'b1);
        press_key("3", 1'b1);
        check_disp("t1");
        chk("t1_bcd_const", disp_bcd, 32'h0000_0123);
        chk("t1_value_const", model_value(), 32'd123);
        run_enter("t1", 1'b1, 0, 1'b0);

        // 2: -40
        press_key("B", 1'b1);
        press_key("4", 1'b1);
        press_key("0", 1'b1);
        check_disp("t2");
        chk("t2_value_const", model_value(), 32'hFFFF_FFD8);
        run_enter("t2", 1'b1, 0, 1'b0);

        // 3: overflowing digit / backspace, or auto-submit when enabled
`ifdef KEYPAD_AUTO_SUBMIT_EN
        for (int d = 1; d <= 8; d++) press_key(byte'("0" + d), 1'b1);
        chk("t3_auto_len", disp_len, 8);
        run_enter("t3_auto", 1'b1, 0, 1'b1);
`else
        for (int d = 1; d <= 9; d++) press_key(byte'("0" + d), 1'b1);
        chk("t3_len8", disp_len, 8);
        chk("t3_bcd8", disp_bcd, 32'h1234_5678);
        press_key("*", 1'b1);
        chk("t3_len7", disp_len, 7);
        chk("t3_nib0", disp_bcd[3:0], 4'd7);
        check_disp("t3");
        press_key("A", 1'b1);
        check_disp("t3_clr");
`endif

        // 4: result held while out_ready stays low
        press_key("5", 1'b1);
        run_enter("t4", 1'b0, 20, 1'b0);

        // 5: malformed coordinate, ignored keys, empty ENTER
        press_key("4", 1'b1);
        press_key("2", 1'b1);
        press_coord(8'h33);
        chk("t5_err_pulse", key_err, 1'b1);
        @(posedge clk);
        chk("t5_err_clear", key_err, 1'b0);
        check_disp("t5_after_err");
        press_key("C", 1'b1);
        press_key("D", 1'b1);
        check_disp("t5_cd");
        press_key("A", 1'b1);
        press_key("#", 1'b0);
        chk("t5_empty_enter_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        chk("t5_empty_enter_valid", out_valid, 1'b0);

        // 6: reset in the middle of an 8-digit conversion
        for (int d = 0; d < 8; d++) press_key(byte'("9" - d), 1'b1);
`ifndef KEYPAD_AUTO_SUBMIT_EN
        press_key("#", 1'b0);
`endif
        @(posedge clk);
        chk("t6_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_len", disp_len, 0);
        chk("t6_rst_bcd", disp_bcd, 0);
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_data", out_data, 0);
        @(posedge clk);
        rst_n = 1'b1;
        mdig.delete();
        mneg = 1'b0;
        @(posedge clk);

        // Random sequences checked against the model
        for (int it = 0; it < 12; it++) begin
            int nops;
            nops = $urandom_range(1, 10);
            for (int j = 0; j < nops; j++) begin
                int r;
                byte k;
                r = $urandom_range(0, 9);
                if (r == 6) k = "*";
                else if (r == 7) k = "B";
                else if (r == 8 && $urandom_range(0, 3) == 0) k = "A";
                else k = byte'("0" + $urandom_range(0, 9));
`ifdef KEYPAD_AUTO_SUBMIT_EN
                if (k >= "0" && k <= "9" && mdig.size() >= MAX_DIGITS - 1) k = "C";
`endif
                press_key(k, 1'b1);
            end
            check_disp($sformatf("rnd%0d", it));
            if (mdig.size() == 0) press_key(byte'("0" + $urandom_range(1, 9)), 1'b1);
            run_enter($sformatf("rnd%0d", it), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 4), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
